// File: rtl/bist_sequencer.sv
// rtl/bist_sequencer.sv - scan-BIST schedule sequencer: seed, shift/capture rounds, unload, signature strobe
module bist_sequencer #(
   parameter int  CHAIN_LEN    = 24,
   parameter int  NUM_PATTERNS = 1000,
   localparam int SC_W         = $clog2(CHAIN_LEN),
   localparam int PC_W         = $clog2(NUM_PATTERNS + 1)
) (
   input  logic            CLK,
   input  logic            RST,
   input  logic            START,
   output logic            SCAN_EN,
   output logic            SEED,
   output logic            LFSR_EN,
   output logic            MISR_CLR,
   output logic            MISR_EN,
   output logic            FINISH,
   output logic            BIST_END,
   output logic            BUSY,
   output logic [PC_W-1:0] PAT_CNT
);

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_INIT    = 3'd1,
      S_SHIFT   = 3'd2,
      S_CAPTURE = 3'd3,
      S_UNLOAD  = 3'd4,
      S_FINISH  = 3'd5,
      S_DONE    = 3'd6
   } state_t;

   state_t          state;
   state_t          state_nxt;
   logic            start_d;
   logic            rise;
   logic [SC_W-1:0] shift_cnt;
   logic            shift_last;
   logic            pat_last;
   logic            pat_full;

   logic scan_en_nxt;
   logic seed_nxt;
   logic lfsr_en_nxt;
   logic misr_clr_nxt;
   logic misr_en_nxt;
   logic finish_nxt;
   logic bist_end_nxt;
   logic busy_nxt;

   assign rise       = START & ~start_d;
   assign shift_last = (shift_cnt == SC_W'(CHAIN_LEN - 1));
   assign pat_last   = (PAT_CNT == PC_W'(NUM_PATTERNS - 1));
   assign pat_full   = (PAT_CNT == PC_W'(NUM_PATTERNS));

   // Next-state selection; dropping START aborts any active phase before FINISH
   always_comb begin
      state_nxt = S_IDLE;
      case (state)
         S_IDLE:    state_nxt = rise ? S_INIT : S_IDLE;
         S_INIT:    state_nxt = START ? S_SHIFT : S_IDLE;
         S_SHIFT: begin
            if (!START)          state_nxt = S_IDLE;
            else if (shift_last) state_nxt = S_CAPTURE;
            else                 state_nxt = S_SHIFT;
         end
         S_CAPTURE: begin
            if (!START)        state_nxt = S_IDLE;
            else if (pat_last) state_nxt = S_UNLOAD;
            else               state_nxt = S_SHIFT;
         end
         S_UNLOAD: begin
            if (!START)          state_nxt = S_IDLE;
            else if (shift_last) state_nxt = S_FINISH;
            else                 state_nxt = S_UNLOAD;
         end
         S_FINISH:  state_nxt = S_DONE;
         S_DONE:    state_nxt = START ? S_DONE : S_IDLE;
         default:   state_nxt = S_IDLE;
      endcase
   end

   // Moore decode of the upcoming state so the output flops line up with the state register
   always_comb begin
      scan_en_nxt  = 1'b0;
      seed_nxt     = 1'b0;
      lfsr_en_nxt  = 1'b0;
      misr_clr_nxt = 1'b0;
      misr_en_nxt  = 1'b0;
      finish_nxt   = 1'b0;
      bist_end_nxt = 1'b0;
      busy_nxt     = 1'b0;
      case (state_nxt)
         S_INIT: begin
            seed_nxt     = 1'b1;
            misr_clr_nxt = 1'b1;
            busy_nxt     = 1'b1;
         end
         S_SHIFT: begin
            scan_en_nxt = 1'b1;
            lfsr_en_nxt = 1'b1;
            misr_en_nxt = 1'b1;
            busy_nxt    = 1'b1;
         end
         S_CAPTURE: begin
            lfsr_en_nxt = 1'b1;
            misr_en_nxt = 1'b1;
            busy_nxt    = 1'b1;
         end
         S_UNLOAD: begin
            scan_en_nxt = 1'b1;
            misr_en_nxt = 1'b1;
            busy_nxt    = 1'b1;
         end
         S_FINISH: begin
            finish_nxt = 1'b1;
            busy_nxt   = 1'b1;
         end
         S_DONE:  bist_end_nxt = 1'b1;
         default: ;
      endcase
   end

   // State, registered outputs and the shift/pattern counters
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state     <= S_IDLE;
         start_d   <= 1'b0;
         shift_cnt <= '0;
         PAT_CNT   <= '0;
         SCAN_EN   <= 1'b0;
         SEED      <= 1'b0;
         LFSR_EN   <= 1'b0;
         MISR_CLR  <= 1'b0;
         MISR_EN   <= 1'b0;
         FINISH    <= 1'b0;
         BIST_END  <= 1'b0;
         BUSY      <= 1'b0;
      end else begin
         state    <= state_nxt;
         start_d  <= START;
         SCAN_EN  <= scan_en_nxt;
         SEED     <= seed_nxt;
         LFSR_EN  <= lfsr_en_nxt;
         MISR_CLR <= misr_clr_nxt;
         MISR_EN  <= misr_en_nxt;
         FINISH   <= finish_nxt;
         BIST_END <= bist_end_nxt;
         BUSY     <= busy_nxt;
         case (state)
            S_IDLE: shift_cnt <= '0;
            S_INIT: begin
               shift_cnt <= '0;
               PAT_CNT   <= '0;
            end
            // shift_cnt serves both the per-pattern shift and the final unload
            S_SHIFT, S_UNLOAD: begin
               if (shift_last) shift_cnt <= '0;
               else            shift_cnt <= shift_cnt + 1'b1;
            end
            // The capture that is in flight still counts even if START drops in it
            S_CAPTURE: begin
               if (!pat_full) PAT_CNT <= PAT_CNT + 1'b1;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_bist_sequencer.sv
// tb/tb_bist_sequencer.sv - scoreboard bench for bist_sequencer
module tb_bist_sequencer;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst_n;
   logic start_a;
   logic start_b;

   logic scan_a, seed_a, lfsr_a, clr_a, men_a, fin_a, end_a, busy_a;
   logic [1:0] pat_a;
   logic scan_b, seed_b, lfsr_b, clr_b, men_b, fin_b, end_b, busy_b;
   logic [0:0] pat_b;

   bist_sequencer #(.CHAIN_LEN(4), .NUM_PATTERNS(3)) dut_a (
      .CLK(clk), .RST(rst_n), .START(start_a),
      .SCAN_EN(scan_a), .SEED(seed_a), .LFSR_EN(lfsr_a), .MISR_CLR(clr_a),
      .MISR_EN(men_a), .FINISH(fin_a), .BIST_END(end_a), .BUSY(busy_a),
      .PAT_CNT(pat_a)
   );

   bist_sequencer #(.CHAIN_LEN(2), .NUM_PATTERNS(1)) dut_b (
      .CLK(clk), .RST(rst_n), .START(start_b),
      .SCAN_EN(scan_b), .SEED(seed_b), .LFSR_EN(lfsr_b), .MISR_CLR(clr_b),
      .MISR_EN(men_b), .FINISH(fin_b), .BIST_END(end_b), .BUSY(busy_b),
      .PAT_CNT(pat_b)
   );

   // {SEED, MISR_CLR, SCAN_EN, LFSR_EN, MISR_EN, FINISH, BUSY, BIST_END}
   logic [7:0] obs_a, obs_b;
   assign obs_a = {seed_a, clr_a, scan_a, lfsr_a, men_a, fin_a, busy_a, end_a};
   assign obs_b = {seed_b, clr_b, scan_b, lfsr_b, men_b, fin_b, busy_b, end_b};

   localparam logic [7:0] V_IDLE = 8'b0000_0000;
   localparam logic [7:0] V_INIT = 8'b1100_0010;
   localparam logic [7:0] V_SHFT = 8'b0011_1010;
   localparam logic [7:0] V_CAPT = 8'b0001_1010;
   localparam logic [7:0] V_UNLD = 8'b0010_1010;
   localparam logic [7:0] V_FINI = 8'b0000_0110;
   localparam logic [7:0] V_DONE = 8'b0000_0001;

   int total = 0;
   int bad   = 0;

   logic [7:0] sb_q[$];

   // invariant monitor: violations and event counts, read back by the main sequence
   int   viol = 0;
   int   fin_cnt_a = 0;
   int   clr_cnt_a = 0;
   logic fin_prev_a = 1'b0;
   logic fin_prev_b = 1'b0;
   always @(negedge clk) begin
      if (rst_n) begin
         viol <= viol
            + int'(fin_a && fin_prev_a) + int'(!busy_a && scan_a) + int'(men_a && clr_a)
            + int'(fin_b && fin_prev_b) + int'(!busy_b && scan_b) + int'(men_b && clr_b);
         fin_cnt_a <= fin_cnt_a + int'(fin_a);
         clr_cnt_a <= clr_cnt_a + int'(clr_a);
      end
      fin_prev_a <= fin_a;
      fin_prev_b <= fin_b;
   end

   // expected output vector in cycle n (n=1 is the cycle after the edge that sees the rise)
   function automatic logic [7:0] exp_vec(input int cl, input int np, input int n);
      int base;
      int off;
      base = 2 + np * (cl + 1);
      if (n == 1) return V_INIT;
      if (n < base) begin
         off = (n - 2) % (cl + 1);
         return (off == cl) ? V_CAPT : V_SHFT;
      end
      if (n < base + cl) return V_UNLD;
      if (n == base + cl) return V_FINI;
      return V_DONE;
   endfunction

   task automatic run_traced(input int which, input int extra);
      int cl, np, fin_n, n, got_fin;
      logic [7:0] e, o;
      cl = (which == 0) ? 4 : 2;
      np = (which == 0) ? 3 : 1;
      fin_n = 2 + np * (cl + 1) + cl;
      if (which == 0) start_a = 1'b1;
      else            start_b = 1'b1;
      for (int i = 1; i <= fin_n + extra; i++) sb_q.push_back(exp_vec(cl, np, i));
      n = 0;
      got_fin = -1;
      while (sb_q.size() > 0) begin
         @(posedge clk); #1;
         n++;
         e = sb_q.pop_front();
         o = (which == 0) ? obs_a : obs_b;
         if (o[2] && got_fin < 0) got_fin = n;
         total++;
         if (o !== e) begin
            bad++;
            $display("FAIL trace dut%0d cycle %0d: got=%b want=%b", which, n, o, e);
         end
      end
      total++;
      if (got_fin !== fin_n) begin
         bad++;
         $display("FAIL finish_cycle dut%0d: got=%0d want=%0d", which, got_fin, fin_n);
      end
   endtask

   task automatic test_reset();
      int nz;
      rst_n = 1'b0; start_a = 1'b0; start_b = 1'b0;
      #12;
      total++;
      if (obs_a !== V_IDLE || pat_a !== 2'd0) begin
         bad++;
         $display("FAIL reset_a: outs=%b pat=%0d want=0/0", obs_a, pat_a);
      end
      total++;
      if (obs_b !== V_IDLE || pat_b !== 1'd0) begin
         bad++;
         $display("FAIL reset_b: outs=%b pat=%0d want=0/0", obs_b, pat_b);
      end
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk); #1;
      start_a = 1'b1;
      repeat (4) @(posedge clk);
      #1;
      total++;
      if (obs_a !== V_SHFT) begin
         bad++;
         $display("FAIL pre_reset_shift: got=%b want=%b", obs_a, V_SHFT);
      end
      #2 rst_n = 1'b0;
      #1;
      total++;
      if (obs_a !== V_IDLE || pat_a !== 2'd0) begin
         bad++;
         $display("FAIL async_reset: outs=%b pat=%0d want=0/0", obs_a, pat_a);
      end
      start_a = 1'b0;
      @(negedge clk) rst_n = 1'b1;
      nz = 0;
      repeat (30) begin
         @(posedge clk); #1;
         if (obs_a !== V_IDLE) nz++;
      end
      total++;
      if (nz !== 0) begin
         bad++;
         $display("FAIL idle_after_reset: active_cycles=%0d want=0", nz);
      end
   endtask

   task automatic test_full_run();
      run_traced(0, 3);
      total++;
      if (pat_a !== 2'd3) begin
         bad++;
         $display("FAIL full_run_pat: got=%0d want=3", pat_a);
      end
   endtask

   task automatic test_hold_rearm();
      int off_cnt;
      int clr0;
      off_cnt = 0;
      repeat (8) begin
         @(posedge clk); #1;
         if (obs_a !== V_DONE) off_cnt++;
      end
      total++;
      if (off_cnt !== 0) begin
         bad++;
         $display("FAIL hold_done: cycles_not_done=%0d want=0", off_cnt);
      end
      start_a = 1'b0;
      @(posedge clk); #1;
      total++;
      if (obs_a !== V_IDLE || pat_a !== 2'd3) begin
         bad++;
         $display("FAIL drop_to_idle: outs=%b pat=%0d want=%b/3", obs_a, pat_a, V_IDLE);
      end
      repeat (2) @(posedge clk);
      #1;
      clr0 = clr_cnt_a;
      run_traced(0, 2);
      #5;
      total++;
      if (clr_cnt_a - clr0 !== 1) begin
         bad++;
         $display("FAIL misr_clr_pulses: got=%0d want=1", clr_cnt_a - clr0);
      end
      total++;
      if (pat_a !== 2'd3) begin
         bad++;
         $display("FAIL rearm_pat: got=%0d want=3", pat_a);
      end
      start_a = 1'b0;
      repeat (3) @(posedge clk);
      #1;
   endtask

   task automatic test_abort();
      int fin0;
      int act;
      fin0 = fin_cnt_a;
      start_a = 1'b1;
      repeat (11) @(posedge clk);
      #1;
      total++;
      if (obs_a !== V_CAPT || pat_a !== 2'd1) begin
         bad++;
         $display("FAIL second_capture: outs=%b pat=%0d want=%b/1", obs_a, pat_a, V_CAPT);
      end
      start_a = 1'b0;
      @(posedge clk); #1;
      total++;
      if (obs_a !== V_IDLE) begin
         bad++;
         $display("FAIL abort_idle: got=%b want=%b", obs_a, V_IDLE);
      end
      act = 0;
      repeat (30) begin
         @(posedge clk); #1;
         if (obs_a !== V_IDLE) act++;
      end
      total++;
      if (act !== 0 || fin_cnt_a !== fin0) begin
         bad++;
         $display("FAIL abort_quiet: active=%0d finishes=%0d want=0/0", act, fin_cnt_a - fin0);
      end
      total++;
      if (pat_a !== 2'd2) begin
         bad++;
         $display("FAIL abort_pat: got=%0d want=2", pat_a);
      end
   endtask

   task automatic test_edge_min();
      run_traced(1, 2);
      total++;
      if (pat_b !== 1'd1) begin
         bad++;
         $display("FAIL edge_pat: got=%0d want=1", pat_b);
      end
      start_b = 1'b0;
      repeat (2) @(posedge clk);
      #1;
   endtask

   task automatic test_invariants();
      total++;
      if (viol !== 0) begin
         bad++;
         $display("FAIL invariants: violations=%0d want=0", viol);
      end
   endtask

   initial begin
      test_reset();
      test_full_run();
      test_hold_rearm();
      test_abort();
      test_edge_min();
      test_invariants();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
